// File: rtl/branch_seq_ctrl.sv
// Instruction-sequencing controller: MEM -> CHECK -> FETCH -> RUN per instruction,
// with a memory-ready timeout, branch flush, short/long run phases, early run
// termination, halt at instruction boundaries, a sticky error state and counters.
module branch_seq_ctrl #(
  parameter int unsigned RUN_CYCLES      = 4,
  parameter int unsigned LONG_RUN_CYCLES = 8,
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             mem_ready,
  input  logic             branch,
  input  logic             long_op,
  input  logic             core_done,
  output logic             run,
  output logic             en_branch,
  output logic             en_fetch,
  output logic             en_memory,
  output logic             busy,
  output logic             timeout_err,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] branch_count
);

  localparam int unsigned RUN_W = (LONG_RUN_CYCLES > 1) ? $clog2(LONG_RUN_CYCLES) : 1;
  localparam int unsigned TO_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
  localparam logic [RUN_W-1:0] LONG_LAST = RUN_W'(LONG_RUN_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StMem   = 3'd1,
    StCheck = 3'd2,
    StFetch = 3'd3,
    StRun   = 3'd4,
    StError = 3'd5
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [RUN_W-1:0] r_run_cnt, w_run_cnt_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
  logic             r_long, w_long_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;
  logic [CNT_W-1:0] r_instr_count, w_instr_count_nxt;
  logic [CNT_W-1:0] r_branch_count, w_branch_count_nxt;
  logic [RUN_W-1:0] w_run_last;

  assign w_run_last   = r_long ? LONG_LAST : RUN_LAST;
  assign state_o      = r_state;
  assign timeout_err  = r_timeout_err;
  assign instr_count  = r_instr_count;
  assign branch_count = r_branch_count;

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_run_cnt      <= '0;
      r_to_cnt       <= '0;
      r_long         <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_instr_count  <= '0;
      r_branch_count <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_run_cnt      <= w_run_cnt_nxt;
      r_to_cnt       <= w_to_cnt_nxt;
      r_long         <= w_long_nxt;
      r_timeout_err  <= w_timeout_err_nxt;
      r_instr_count  <= w_instr_count_nxt;
      r_branch_count <= w_branch_count_nxt;
    end
  end

  // Next-state logic and Moore enables decoded from the current state.
  always_comb begin
    w_state_nxt        = r_state;
    w_run_cnt_nxt      = r_run_cnt;
    w_to_cnt_nxt       = r_to_cnt;
    w_long_nxt         = r_long;
    w_timeout_err_nxt  = r_timeout_err;
    w_instr_count_nxt  = r_instr_count;
    w_branch_count_nxt = r_branch_count;
    run                = 1'b0;
    en_branch          = 1'b0;
    en_fetch           = 1'b0;
    en_memory          = 1'b0;
    busy               = 1'b0;

    case (r_state)
      StIdle: begin
        if (!halt) w_state_nxt = StMem;
      end
      StMem: begin
        en_memory = 1'b1;
        busy      = 1'b1;
        // A ready on the final allowed cycle still counts as success.
        if (mem_ready) begin
          w_state_nxt  = StCheck;
          w_to_cnt_nxt = '0;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_nxt       = StError;
          w_timeout_err_nxt = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      StCheck: begin
        en_branch   = 1'b1;
        busy        = 1'b1;
        w_state_nxt = StFetch;
      end
      StFetch: begin
        en_fetch = 1'b1;
        busy     = 1'b1;
        // Taken branch flushes the fetched instruction; long_op is irrelevant then.
        if (branch) begin
          w_state_nxt        = StMem;
          w_branch_count_nxt = r_branch_count + 1'b1;
        end else begin
          w_long_nxt    = long_op;
          w_run_cnt_nxt = '0;
          w_state_nxt   = StRun;
        end
      end
      StRun: begin
        run           = 1'b1;
        busy          = 1'b1;
        w_run_cnt_nxt = r_run_cnt + 1'b1;
        if (core_done || (r_run_cnt == w_run_last)) begin
          w_instr_count_nxt = r_instr_count + 1'b1;
          w_state_nxt       = halt ? StIdle : StMem;
        end
      end
      StError: begin
        w_timeout_err_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl: a per-cycle vector table for the main flow,
// then hand-written sequences for timeouts, resets, halt and counter wrap.
module tb_branch_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, halt, mem_ready, branch, long_op, core_done;
  logic        run, en_branch, en_fetch, en_memory, busy, timeout_err;
  logic [2:0]  state_o;
  logic [31:0] instr_count, branch_count;

  // Small instance: 1-cycle runs, 1-cycle timeout, 4-bit counters.
  logic        s_reset, s_halt, s_mem_ready;
  logic        s_run, s_en_branch, s_en_fetch, s_en_memory, s_busy, s_timeout_err;
  logic [2:0]  s_state;
  logic [3:0]  s_instr, s_branch;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_seq_ctrl u_dut (
    .clk(clk), .reset(reset), .halt(halt), .mem_ready(mem_ready), .branch(branch),
    .long_op(long_op), .core_done(core_done), .run(run), .en_branch(en_branch),
    .en_fetch(en_fetch), .en_memory(en_memory), .busy(busy), .timeout_err(timeout_err),
    .state_o(state_o), .instr_count(instr_count), .branch_count(branch_count)
  );

  branch_seq_ctrl #(
    .RUN_CYCLES(1), .LONG_RUN_CYCLES(1), .MEM_TIMEOUT(1), .CNT_W(4)
  ) u_small (
    .clk(clk), .reset(s_reset), .halt(s_halt), .mem_ready(s_mem_ready), .branch(1'b0),
    .long_op(1'b0), .core_done(1'b0), .run(s_run), .en_branch(s_en_branch),
    .en_fetch(s_en_fetch), .en_memory(s_en_memory), .busy(s_busy),
    .timeout_err(s_timeout_err), .state_o(s_state), .instr_count(s_instr),
    .branch_count(s_branch)
  );

  typedef struct {
    logic [2:0] st;
    logic       h, mr, br, lo, cd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] st, input logic h, mr, br, lo, cd);
    vec_t v;
    v.st = st; v.h = h; v.mr = mr; v.br = br; v.lo = lo; v.cd = cd;
    vecs.push_back(v);
  endtask

  // Expected {run, en_branch, en_fetch, en_memory, busy} for a state.
  function automatic logic [4:0] exp_en(input logic [2:0] st);
    case (st)
      3'd1:    return 5'b00011;
      3'd2:    return 5'b01001;
      3'd3:    return 5'b00101;
      3'd4:    return 5'b10001;
      default: return 5'b00000;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with the DUT in IDLE.
  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n_mem;
    int runs;
    logic run_seen;

    reset = 1'b1; halt = 1'b0; mem_ready = 1'b1; branch = 1'b0;
    long_op = 1'b0; core_done = 1'b0;
    s_reset = 1'b1; s_halt = 1'b0; s_mem_ready = 1'b1;

    // Main flow table: state, halt, mem_ready, branch, long_op, core_done.
    add(0,0,1,0,0,0); add(1,0,1,0,0,0); add(2,0,1,0,0,0); add(3,0,1,0,0,0);
    for (int i = 0; i < 4; i++) add(4,0,0,0,0,0);  // mem_ready ignored in RUN
    add(1,0,1,0,0,0); add(2,0,1,0,0,0); add(3,0,1,1,0,0);  // taken branch
    add(1,0,1,0,0,0); add(2,0,1,0,0,0); add(3,0,1,0,1,0);  // long op
    for (int i = 0; i < 8; i++) add(4,0,1,0,0,0);
    add(1,0,1,0,0,0); add(2,0,1,0,0,0); add(3,0,1,0,1,0);  // long op, early done
    add(4,0,1,0,0,0); add(4,0,1,0,0,0); add(4,0,1,0,0,1);
    add(1,0,1,0,0,0); add(2,0,1,0,0,0); add(3,0,1,1,1,0);  // branch beats long_op
    add(1,0,1,0,0,0); add(2,0,1,0,0,1); add(3,0,1,0,0,1);  // core_done ignored
    add(4,0,1,0,0,0); add(4,1,1,0,0,0); add(4,1,1,0,0,0); add(4,1,1,0,0,0);  // halt
    add(0,1,1,0,0,0); add(0,0,1,0,0,0);
    add(1,0,1,0,0,0); add(2,0,1,0,0,0); add(3,0,1,0,0,0);
    add(4,0,1,0,0,1);                                       // done in first RUN cycle
    add(1,0,0,0,0,0); add(1,0,1,0,0,0); add(2,0,1,0,0,0);  // one-cycle mem stall

    @(negedge clk);
    reset_dut();
    chk("reset_state", state_o, 3'd0);
    chk("reset_enables", {run, en_branch, en_fetch, en_memory, busy}, 5'b0);
    chk("reset_timeout_err", timeout_err, 1'b0);
    chk("reset_instr_count", instr_count, 32'd0);
    chk("reset_branch_count", branch_count, 32'd0);

    foreach (vecs[i]) begin
      halt = vecs[i].h; mem_ready = vecs[i].mr; branch = vecs[i].br;
      long_op = vecs[i].lo; core_done = vecs[i].cd;
      chk($sformatf("vec%0d_state", i), state_o, vecs[i].st);
      chk($sformatf("vec%0d_enables", i), {run, en_branch, en_fetch, en_memory, busy},
          exp_en(vecs[i].st));
      @(negedge clk);
    end
    chk("table_instr_count", instr_count, 32'd5);
    chk("table_branch_count", branch_count, 32'd2);

    // Back-to-back normal instructions, 7 cycles each.
    halt = 1'b0; mem_ready = 1'b1; branch = 1'b0; long_op = 1'b0; core_done = 1'b0;
    reset_dut();
    repeat (8) @(negedge clk);
    chk("first_exit_state", state_o, 3'd1);
    chk("first_exit_instr", instr_count, 32'd1);
    repeat (14) @(negedge clk);
    chk("third_exit_instr", instr_count, 32'd3);
    chk("third_exit_state", state_o, 3'd1);

    // Reset in the third RUN cycle.
    repeat (5) @(negedge clk);
    chk("run3_state", state_o, 3'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_reset_state", state_o, 3'd0);
    chk("midrun_reset_run", run, 1'b0);
    chk("midrun_reset_instr", instr_count, 32'd0);

    // Five taken branches in a row.
    branch = 1'b1;
    run_seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (run) run_seen = 1'b1;
    end
    chk("branch5_state", state_o, 3'd1);
    chk("branch5_count", branch_count, 32'd5);
    chk("branch5_instr", instr_count, 32'd0);
    chk("branch5_no_run", run_seen, 1'b0);

    // Memory never ready: 15 MEM cycles then sticky ERROR.
    branch = 1'b0; mem_ready = 1'b0;
    n_mem = 0;
    for (int i = 0; i < 40; i++) begin
      if (en_memory) n_mem++;
      @(negedge clk);
    end
    chk("timeout_mem_cycles", n_mem, 15);
    chk("timeout_state", state_o, 3'd5);
    chk("timeout_err_flag", timeout_err, 1'b1);
    chk("timeout_enables", {run, en_branch, en_fetch, en_memory, busy}, 5'b0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("error_sticky_state", state_o, 3'd5);
    reset_dut();
    chk("err_reset_state", state_o, 3'd0);
    chk("err_reset_flag", timeout_err, 1'b0);
    chk("err_reset_branch", branch_count, 32'd0);

    // Ready arriving on the 15th MEM cycle still succeeds.
    mem_ready = 1'b0;
    repeat (15) @(negedge clk);
    chk("mem15_state", state_o, 3'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mem15_ready_state", state_o, 3'd2);
    chk("mem15_no_error", timeout_err, 1'b0);

    // Small instance: 4-bit instr_count wraps after 16 instructions.
    s_reset = 1'b1;
    repeat (2) @(negedge clk);
    s_reset = 1'b0;
    runs = 0;
    for (int i = 0; i < 200 && runs < 16; i++) begin
      @(negedge clk);
      if (s_state == 3'd4) begin
        runs++;
        if (runs == 16) chk("wrap_instr_before", s_instr, 4'd15);
      end
    end
    chk("wrap_runs_seen", runs, 16);
    @(negedge clk);
    chk("wrap_instr_after", s_instr, 4'd0);
    chk("wrap_state", s_state, 3'd1);
    s_mem_ready = 1'b0;
    @(negedge clk);
    chk("timeout1_state", s_state, 3'd5);
    chk("timeout1_flag", s_timeout_err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
